// File: rtl/hazard_ctrl_if.sv
// Bundle of hazard-detection inputs from the ID/EX/MEM stages and the pipeline
// control outputs. The pipeline side drives through master; the controller uses slave.
interface hazard_ctrl_if #(
    parameter int PC_W  = 16,
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
);
  logic [RA_W-1:0]  id_rs1;
  logic [RA_W-1:0]  id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [RA_W-1:0]  ex_rd;
  logic             ex_is_load;
  logic             ex_reg_write;
  logic             ex_jb_taken;
  logic [PC_W-1:0]  ex_jb_target;
  logic             dmem_req;
  logic             dmem_ready;
  logic             stall;
  logic             freeze;
  logic             jb;
  logic             pc_sel;
  logic [PC_W-1:0]  pc_target;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic             mem_timeout;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load, ex_reg_write,
           ex_jb_taken, ex_jb_target, dmem_req, dmem_ready,
    input  stall, freeze, jb, pc_sel, pc_target, stall_count, flush_count, mem_timeout
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load, ex_reg_write,
           ex_jb_taken, ex_jb_target, dmem_req, dmem_ready,
    output stall, freeze, jb, pc_sel, pc_target, stall_count, flush_count, mem_timeout
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, memory-wait freeze, jump/branch
// flush and redirect sequencing, plus saturating event counters and a sticky timeout.
module hazard_ctrl #(
  parameter int PC_W         = 16,
  parameter int RA_W         = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 32
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {RUN, FREEZE, REDIRECT} state_t;

  localparam int TC_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [2:0]      FLUSH_EXTRA = 3'(FLUSH_CYCLES - 1);
  localparam logic [TC_W-1:0] TC_MAX      = TC_W'(MEM_TIMEOUT - 1);
  localparam logic [TC_W-1:0] TC_SET      = TC_W'(MEM_TIMEOUT - 2);

  state_t           state_reg;
  logic [2:0]       flush_left_reg;
  logic [TC_W-1:0]  tcnt_reg;
  logic             timeout_reg;
  logic [CNT_W-1:0] stall_count_reg;
  logic [CNT_W-1:0] flush_count_reg;

  logic lu, mw;
  logic stall_c, freeze_c, jb_c, pc_sel_c;

  assign mw = hz.dmem_req & ~hz.dmem_ready;
  assign lu = hz.ex_is_load & hz.ex_reg_write & (hz.ex_rd != '0) &
              ((hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd)) |
               (hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd)));

  // Mealy controls: the pipeline registers act on these in the same cycle.
  always_comb begin
    stall_c  = 1'b0;
    freeze_c = 1'b0;
    jb_c     = 1'b0;
    pc_sel_c = 1'b0;
    case (state_reg)
      REDIRECT: begin
        if (mw) freeze_c = 1'b1;
        else    jb_c     = 1'b1;
      end
      default: begin
        // FREEZE releasing into a non-waiting cycle is evaluated exactly like RUN.
        if (mw) begin
          freeze_c = 1'b1;
        end else if (hz.ex_jb_taken) begin
          jb_c     = 1'b1;
          pc_sel_c = 1'b1;
        end else if (lu) begin
          stall_c  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= RUN;
      flush_left_reg  <= '0;
      tcnt_reg        <= '0;
      timeout_reg     <= 1'b0;
      stall_count_reg <= '0;
      flush_count_reg <= '0;
    end else begin
      case (state_reg)
        REDIRECT: begin
          // The flush countdown pauses while memory holds the pipeline.
          if (!mw) begin
            flush_left_reg <= flush_left_reg - 3'd1;
            if (flush_left_reg <= 3'd1) state_reg <= RUN;
          end
        end
        default: begin
          if (mw) begin
            state_reg <= FREEZE;
          end else if (hz.ex_jb_taken) begin
            flush_left_reg <= FLUSH_EXTRA;
            state_reg      <= (FLUSH_CYCLES > 1) ? REDIRECT : RUN;
          end else begin
            state_reg <= RUN;
          end
        end
      endcase

      if (freeze_c) begin
        if (tcnt_reg != TC_MAX) tcnt_reg <= tcnt_reg + TC_W'(1);
        if (tcnt_reg >= TC_SET) timeout_reg <= 1'b1;
      end else begin
        tcnt_reg <= '0;
      end

      if ((stall_c | freeze_c) && !(&stall_count_reg))
        stall_count_reg <= stall_count_reg + CNT_W'(1);
      if (pc_sel_c && !(&flush_count_reg))
        flush_count_reg <= flush_count_reg + CNT_W'(1);
    end
  end

  assign hz.stall       = stall_c;
  assign hz.freeze      = freeze_c;
  assign hz.jb          = jb_c;
  assign hz.pc_sel      = pc_sel_c;
  assign hz.pc_target   = pc_sel_c ? hz.ex_jb_target : '0;
  assign hz.stall_count = stall_count_reg;
  assign hz.flush_count = flush_count_reg;
  assign hz.mem_timeout = timeout_reg;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with FLUSH_CYCLES=2 and MEM_TIMEOUT=4.
module tb_hazard_ctrl;
  localparam int PC_W  = 16;
  localparam int RA_W  = 5;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.PC_W(PC_W), .RA_W(RA_W), .CNT_W(CNT_W)) bus ();

  hazard_ctrl #(
    .PC_W(PC_W), .RA_W(RA_W), .FLUSH_CYCLES(2), .MEM_TIMEOUT(4), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("check %s: got %0h ok", tag, obs);
    end
  endtask

  task automatic clear_inputs();
    bus.id_rs1 = '0;  bus.id_rs2 = '0;  bus.id_use_rs1 = 1'b0;  bus.id_use_rs2 = 1'b0;
    bus.ex_rd = '0;   bus.ex_is_load = 1'b0;  bus.ex_reg_write = 1'b0;
    bus.ex_jb_taken = 1'b0;  bus.ex_jb_target = '0;
    bus.dmem_req = 1'b0;     bus.dmem_ready = 1'b0;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_lu(input logic [RA_W-1:0] rd);
    bus.ex_is_load = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_rd = rd;
    bus.id_rs2 = rd; bus.id_use_rs2 = 1'b1;
  endtask

  initial begin
    clear_inputs();
    do_reset();
    settle();
    check("rst_stall",  32'(bus.stall), 32'd0);
    check("rst_freeze", 32'(bus.freeze), 32'd0);
    check("rst_jb",     32'(bus.jb), 32'd0);
    check("rst_pc_sel", 32'(bus.pc_sel), 32'd0);
    check("rst_target", 32'(bus.pc_target), 32'd0);
    check("rst_scnt",   bus.stall_count, 32'd0);
    check("rst_fcnt",   bus.flush_count, 32'd0);
    check("rst_tmo",    32'(bus.mem_timeout), 32'd0);

    // Load-use on rs2
    set_lu(5'd5);
    settle();
    check("lu_stall",  32'(bus.stall), 32'd1);
    check("lu_freeze", 32'(bus.freeze), 32'd0);
    check("lu_jb",     32'(bus.jb), 32'd0);
    tick();
    bus.ex_is_load = 1'b0;
    settle();
    check("lu_bubble_stall", 32'(bus.stall), 32'd0);
    check("lu_scnt", bus.stall_count, 32'd1);

    // rd = x0 never stalls; unused source never stalls; used rs1 stalls
    clear_inputs();
    bus.ex_is_load = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_rd = 5'd0;
    bus.id_rs1 = 5'd0; bus.id_use_rs1 = 1'b1;
    settle();
    check("x0_stall", 32'(bus.stall), 32'd0);
    tick();
    bus.ex_rd = 5'd7; bus.id_rs1 = 5'd7; bus.id_use_rs1 = 1'b0;
    settle();
    check("nouse_stall", 32'(bus.stall), 32'd0);
    bus.id_use_rs1 = 1'b1;
    settle();
    check("rs1_stall", 32'(bus.stall), 32'd1);
    bus.ex_reg_write = 1'b0;
    settle();
    check("nowr_stall", 32'(bus.stall), 32'd0);
    bus.ex_reg_write = 1'b1;
    tick();
    clear_inputs();
    settle();
    check("rs1_scnt", bus.stall_count, 32'd2);

    // Branch with a concurrent load-use: jb wins, two flush cycles
    bus.ex_jb_taken = 1'b1; bus.ex_jb_target = 16'h0040;
    set_lu(5'd3);
    settle();
    check("br0_jb",     32'(bus.jb), 32'd1);
    check("br0_pc_sel", 32'(bus.pc_sel), 32'd1);
    check("br0_target", 32'(bus.pc_target), 32'h0040);
    check("br0_stall",  32'(bus.stall), 32'd0);
    tick();
    bus.ex_jb_target = 16'h0080;
    settle();
    check("br1_jb",     32'(bus.jb), 32'd1);
    check("br1_pc_sel", 32'(bus.pc_sel), 32'd0);
    check("br1_target", 32'(bus.pc_target), 32'd0);
    check("br1_stall",  32'(bus.stall), 32'd0);
    tick();
    clear_inputs();
    settle();
    check("br2_jb",   32'(bus.jb), 32'd0);
    check("br_fcnt",  bus.flush_count, 32'd1);
    check("br_scnt",  bus.stall_count, 32'd2);

    // Freeze with a pending branch: jb issued once on release
    do_reset();
    bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
    bus.ex_jb_taken = 1'b1; bus.ex_jb_target = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("frz%0d_freeze", i), 32'(bus.freeze), 32'd1);
      check($sformatf("frz%0d_jb", i), 32'(bus.jb), 32'd0);
      tick();
    end
    bus.dmem_ready = 1'b1;
    settle();
    check("rel_freeze", 32'(bus.freeze), 32'd0);
    check("rel_jb",     32'(bus.jb), 32'd1);
    check("rel_pc_sel", 32'(bus.pc_sel), 32'd1);
    check("rel_target", 32'(bus.pc_target), 32'h1234);
    check("rel_scnt",   bus.stall_count, 32'd3);
    tick();
    clear_inputs();
    settle();
    check("rel1_jb",     32'(bus.jb), 32'd1);
    check("rel1_pc_sel", 32'(bus.pc_sel), 32'd0);
    tick();
    settle();
    check("rel2_jb",   32'(bus.jb), 32'd0);
    check("rel_fcnt",  bus.flush_count, 32'd1);

    // Memory wait during REDIRECT pauses the flush sequence
    bus.ex_jb_taken = 1'b1; bus.ex_jb_target = 16'h0200;
    tick();
    bus.ex_jb_taken = 1'b0; bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
    settle();
    check("rdmw_freeze", 32'(bus.freeze), 32'd1);
    check("rdmw_jb",     32'(bus.jb), 32'd0);
    tick();
    bus.dmem_req = 1'b0;
    settle();
    check("rdres_jb",     32'(bus.jb), 32'd1);
    check("rdres_pc_sel", 32'(bus.pc_sel), 32'd0);
    tick();
    settle();
    check("rdend_jb",   32'(bus.jb), 32'd0);
    check("rdend_fcnt", bus.flush_count, 32'd2);

    // Timeout: sets from the 4th wait cycle, sticky until reset
    do_reset();
    bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      settle();
      check($sformatf("tmo_cyc%0d", i), 32'(bus.mem_timeout), (i >= 4) ? 32'd1 : 32'd0);
      tick();
    end
    bus.dmem_req = 1'b0;
    settle();
    check("tmo_sticky", 32'(bus.mem_timeout), 32'd1);
    check("tmo_freeze", 32'(bus.freeze), 32'd0);
    check("tmo_scnt",   bus.stall_count, 32'd6);
    tick();
    check("tmo_hold",   32'(bus.mem_timeout), 32'd1);
    do_reset();
    settle();
    check("tmo_rst", 32'(bus.mem_timeout), 32'd0);

    // Reset during the second flush cycle aborts to RUN
    bus.ex_jb_taken = 1'b1; bus.ex_jb_target = 16'h0100;
    tick();
    bus.ex_jb_taken = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check("rstrd_jb",   32'(bus.jb), 32'd0);
    check("rstrd_fcnt", bus.flush_count, 32'd0);
    bus.ex_jb_taken = 1'b1; bus.ex_jb_target = 16'h0300;
    settle();
    check("rstrd_run_pc_sel", 32'(bus.pc_sel), 32'd1);
    check("rstrd_run_target", 32'(bus.pc_target), 32'h0300);
    tick();
    clear_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
